// File: rtl/acam_fifo_readout_ctrl.sv
// Read sequencer for ACAM TDC-GPX FIFO1: waits on the synchronised empty flag,
// strobes RD_N/OE_N, captures each raw timestamp and offers it on a valid/ready stream.
module acam_fifo_readout_ctrl #(
  parameter int g_data_width      = 28,
  parameter int g_rd_pulse_cycles = 4,
  parameter int g_rd_recovery     = 2,
  parameter int g_ef_sync_stages  = 2
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_a_i,
  input  logic                    enable_i,
  input  logic                    ef1_i,
  input  logic [g_data_width-1:0] data_i,
  output logic                    rd_n_o,
  output logic                    oe_n_o,
  output logic [g_data_width-1:0] ts_o,
  output logic                    ts_valid_o,
  input  logic                    ts_ready_i,
  output logic                    busy_o,
  output logic [31:0]             rd_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    LATCH,
    RECOVER,
    WAIT_ACK
  } state_t;

  localparam int         rec_cycles = g_rd_recovery + g_ef_sync_stages;
  localparam logic [3:0] pulse_last = 4'(g_rd_pulse_cycles - 1);
  localparam logic [7:0] rec_last   = 8'(rec_cycles - 1);

  state_t                    state;
  state_t                    state_next;
  logic [g_ef_sync_stages-1:0] ef_sync;
  logic                      ef_s;
  logic [3:0]                strobe_cnt;
  logic [7:0]                recover_cnt;
  logic                      capture;
  logic                      rd_n;
  logic                      oe_n;
  logic                      busy;
  logic                      ts_valid;
  logic [g_data_width-1:0]   ts;
  logic [31:0]               rd_count;

  // Empty flag resets to "empty" so nothing is read until the flag is seen low.
  always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      ef_sync <= '1;
    end else begin
      ef_sync <= {ef_sync[g_ef_sync_stages-2:0], ef1_i};
    end
  end

  assign ef_s = ef_sync[g_ef_sync_stages-1];

  always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      state       <= IDLE;
      strobe_cnt  <= '0;
      recover_cnt <= '0;
    end else begin
      state       <= state_next;
      strobe_cnt  <= (state == STROBE)  ? strobe_cnt + 4'd1  : 4'd0;
      recover_cnt <= (state == RECOVER) ? recover_cnt + 8'd1 : 8'd0;
    end
  end

  // A word still waiting downstream blocks new reads, so the ACAM FIFO absorbs backpressure.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && !ef_s && !ts_valid) begin
          state_next = STROBE;
        end
      end
      STROBE: begin
        if (strobe_cnt == pulse_last) begin
          capture    = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH: begin
        state_next = RECOVER;
      end
      RECOVER: begin
        if (recover_cnt == rec_last) begin
          if (!enable_i || !ts_valid) begin
            state_next = IDLE;
          end else begin
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (!ts_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so the ACAM pins never see decode glitches.
  always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      rd_n <= 1'b1;
      oe_n <= 1'b1;
      busy <= 1'b0;
    end else begin
      rd_n <= (state_next != STROBE);
      oe_n <= (state_next == IDLE);
      busy <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
    if (!rst_n_a_i) begin
      ts       <= '0;
      ts_valid <= 1'b0;
      rd_count <= '0;
    end else begin
      if (capture) begin
        ts <= data_i;
      end
      if (ts_valid && ts_ready_i) begin
        ts_valid <= 1'b0;
      end
      if (state == LATCH) begin
        ts_valid <= 1'b1;
        rd_count <= rd_count + 32'd1;
      end
    end
  end

  assign rd_n_o     = rd_n;
  assign oe_n_o     = oe_n;
  assign busy_o     = busy;
  assign ts_o       = ts;
  assign ts_valid_o = ts_valid;
  assign rd_count_o = rd_count;

endmodule
